ascon_serial_hash: RTL and testbench
====================================

Name: ascon_serial_hash

Overview:
- Serial-I/O Ascon-Hash/Ascon-Hasha (v1.2) core.
- Shifts in a y-bit message one bit per clock, pads it, absorbs it and squeezes an l-bit digest using one permutation round per clock.
- Shifts the digest out one bit per clock.
- Sits behind a bit-serial host interface; no internal memory beyond the 320-bit state.

Parameters:
- r, 64: rate in bits. Only 64 is supported; the rate lane is x0.
- a, 12: rounds for initialisation and final absorb (p^a).
- b, 12: rounds between blocks (p^b). Use 12 for Ascon-Hash, 8 for Ascon-Hasha.
- h, 256: hash length field placed in the IV.
- l, 256: number of digest bits produced, l ≥ 1.
- y, 64: message length in bits, y ≥ 1.

Ports:
- clk, input, 1: clock, rising-edge active.
- rst, input, 1: asynchronous, active-high reset.
- messagexSI, input, 1: serial message bit, MSB (first Ascon message bit) first.
- startxSI, input, 1: start request; its rising edge is the event.
- hash_digestxSO, output, 1: serial digest bit, D[0] first.
- hash_readyxSO, output, 1: high when the digest is available.

Behaviour:
- Reset: FSM goes to IDLE. Message register, state, digest register and start-edge flop all clear to 0. Both outputs are 0. Reset applies immediately in any state, including mid-permutation.
- Message capture (IDLE and DONE): at every rising edge, M <= {M[y-2:0], messagexSI}. This includes the edge at which a start is accepted. The message is the last y bits shifted in.
- Start acceptance: start is accepted when startxSI=1 and its registered value is 0, and the FSM is in IDLE or DONE. Start is ignored in all other states. Accepting start clears hash_readyxSO.
- Padding: P = M || 1 || 0^k, with the minimal k making |P| a multiple of 64. Block count s = floor(y/64)+1. An extra full block is appended when y mod 64 = 0.
- IV: {8'h00, r[7:0], a[7:0], (a-b)[7:0], h[31:0]}.
- Sequence, one cycle per step after the accept edge:
  1. LOAD: state <= IV || 0^256 (1 cycle).
  2. a rounds.
  3. For each block i<s: x0 ^= P_i (1 cycle), then b rounds.
  4. Last block: x0 ^= P_s (1 cycle), then a rounds.
  5. Squeeze t = ceil(l/64) lanes: capture x0 (1 cycle), with b rounds between captures.
  6. Go to DONE.
- Latency: ready rises at edge number 1+a+(s-1)(1+b)+(1+a)+t+(t-1)b after the accept edge. For the defaults this is 79.
- Permutation round, rounds numbered so p^n uses constants at indices 12-n..11 with c_i = ((15-i)<<4)|i:
  - Add constant: x2 ^= c_i.
  - Ascon 5-bit S-box, bitsliced over x0..x4.
  - Linear layer, rotations right:
    - x0: 19, 28
    - x1: 61, 39
    - x2: 1, 6
    - x3: 10, 17
    - x4: 7, 41
  - Lane x0 bit 63 holds the first message bit of a block.
- Digest: H = the first l bits of the concatenated squeezed lanes, where lane 1 bit 63 is H[l-1]. Register D <= H at the ready edge E0.
- Serial output:
  - hash_digestxSO = D[0] always.
  - D shifts right, filling with 0, at every edge from E3 onward.
  - So H[0] is valid from E0 to E3, and H[k] is valid from E(2+k) to E(3+k).
- hash_readyxSO stays high in DONE until reset or the next accepted start.

Optional Feature:
- Macro ASCON_HASH_STATE_DBG_EN.
  - Defined: adds output port state_dbgxSO [319:0] = {x0,x1,x2,x3,x4}, registered, reset 0.
  - Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- Defaults (r=64, a=12, b=12, h=256, l=256), ASCON_HASH_STATE_DBG_EN defined, start pulse -> after LOAD plus 12 rounds, state_dbgxSO = ee9398aadb67f03d 8bb21831c60f1002 b48a92db98d5da62 43189921b8f8e3e8 348fa5c9d525e140.
- y=64, message 0x0001020304050607, startxSI high 3 cycles -> hash_readyxSO rises 79 edges after the accept edge. The 256 bits read from E3 onward equal the Ascon-Hash reference model digest of those 8 bytes.
- y=8, a=12, b=8 (Ascon-Hasha), message 0x00 -> digest matches the reference Ascon-Hasha, IV 00400c0400000100.
- Apply rst mid-absorb -> outputs 0 immediately. A new load and start then yields the correct digest.
- Toggle startxSI during permutation -> ignored. The digest and latency are unchanged.
- After DONE, shift a new message and pulse start -> ready drops on the accept edge. The second digest is correct.

Source files
------------

// File: rtl/ascon_serial_hash.sv
// Bit-serial Ascon-Hash / Ascon-Hasha core, one permutation round per clock.
// Define ASCON_HASH_STATE_DBG_EN to expose the 320-bit state on state_dbgxSO.
module ascon_serial_hash #(
  parameter int unsigned R = 64,
  parameter int unsigned A = 12,
  parameter int unsigned B = 12,
  parameter int unsigned H = 256,
  parameter int unsigned L = 256,
  parameter int unsigned Y = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         messagexSI,
  input  logic         startxSI,
`ifdef ASCON_HASH_STATE_DBG_EN
  output logic [319:0] state_dbgxSO,
`else
`endif
  output logic         hash_digestxSO,
  output logic         hash_readyxSO
);

  localparam int unsigned S     = Y / 64 + 1;
  localparam int unsigned T     = (L + 63) / 64;
  localparam int unsigned PW    = S * 64;
  localparam int unsigned TW    = T * 64;
  localparam int unsigned BlkW  = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned LaneW = (T > 1) ? $clog2(T) : 1;

  localparam logic [BlkW-1:0]  SLast = BlkW'(S - 1);
  localparam logic [LaneW-1:0] TLast = LaneW'(T - 1);
  localparam logic [3:0]       ALast = 4'(A - 1);
  localparam logic [3:0]       BLast = 4'(B - 1);
  localparam logic [3:0]       AOff  = 4'(12 - A);
  localparam logic [3:0]       BOff  = 4'(12 - B);
  localparam logic [63:0]      IV    = {8'h00, 8'(R), 8'(A), 8'(A - B), 32'(H)};

  typedef enum logic [2:0] {
    StIdle, StLoad, StInitRnd, StAbsorb, StAbsRnd, StSqueeze, StSqRnd, StDone
  } state_e;

  state_e            r_fsm;
  logic              r_start_q;
  logic [Y-1:0]      r_msg;
  logic [319:0]      r_st;
  logic [3:0]        r_rnd;
  logic [BlkW-1:0]   r_blk;
  logic [LaneW-1:0]  r_lane;
  logic [TW-1:0]     r_sq;
  logic [L-1:0]      r_dig;
  logic [1:0]        r_dly;
  logic              r_ready;

  logic              w_accept;
  logic              w_last_blk;
  logic [3:0]        w_rc_idx;
  logic [319:0]      w_rnd_st;
  logic [PW-1:0]     w_pad;
  logic [63:0]       w_blk;
  logic [TW-1:0]     w_cat;

  function automatic logic [319:0] ascon_round(logic [319:0] s, logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, c};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  assign w_accept   = startxSI & ~r_start_q & ((r_fsm == StIdle) | (r_fsm == StDone));
  assign w_last_blk = (r_blk == SLast);
  assign w_rnd_st   = ascon_round(r_st, {~w_rc_idx, w_rc_idx});
  // Message then a single 1 bit, left-aligned in S blocks; lane bit 63 is the first bit.
  assign w_pad      = (PW'(r_msg) << (PW - Y)) | (PW'(1) << (PW - Y - 1));
  assign w_cat      = (r_sq << 64) | TW'(r_st[319:256]);

  // p^n uses constant indices 12-n .. 11.
  always_comb begin
    w_rc_idx = BOff + r_rnd;
    case (r_fsm)
      StInitRnd: w_rc_idx = AOff + r_rnd;
      StAbsRnd:  w_rc_idx = (w_last_blk ? AOff : BOff) + r_rnd;
      default:   w_rc_idx = BOff + r_rnd;
    endcase
  end

  always_comb begin
    w_blk = '0;
    for (int i = 0; i < S; i++) begin
      if (r_blk == BlkW'(i)) w_blk = w_pad[PW-1-64*i -: 64];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= StIdle;
      r_start_q <= 1'b0;
      r_msg     <= '0;
      r_st      <= '0;
      r_rnd     <= '0;
      r_blk     <= '0;
      r_lane    <= '0;
      r_sq      <= '0;
      r_dig     <= '0;
      r_dly     <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_start_q <= startxSI;
      // Digest holds D[0] for three edges after loading, then shifts once per edge.
      if (r_dly != 2'd2) r_dly <= r_dly + 2'd1;
      else               r_dig <= r_dig >> 1;
      case (r_fsm)
        StIdle, StDone: begin
          r_msg <= Y'({r_msg, messagexSI});
          if (w_accept) begin
            r_fsm   <= StLoad;
            r_ready <= 1'b0;
          end
        end
        StLoad: begin
          r_st  <= {IV, 256'd0};
          r_rnd <= '0;
          r_fsm <= StInitRnd;
        end
        StInitRnd: begin
          r_st  <= w_rnd_st;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == ALast) begin
            r_blk <= '0;
            r_fsm <= StAbsorb;
          end
        end
        StAbsorb: begin
          r_st[319:256] <= r_st[319:256] ^ w_blk;
          r_rnd         <= '0;
          r_fsm         <= StAbsRnd;
        end
        StAbsRnd: begin
          r_st  <= w_rnd_st;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == (w_last_blk ? ALast : BLast)) begin
            if (w_last_blk) begin
              r_lane <= '0;
              r_fsm  <= StSqueeze;
            end else begin
              r_blk <= r_blk + 1'b1;
              r_fsm <= StAbsorb;
            end
          end
        end
        StSqueeze: begin
          r_sq <= w_cat;
          if (r_lane == TLast) begin
            r_dig   <= L'(w_cat >> (TW - L));
            r_dly   <= 2'd0;
            r_ready <= 1'b1;
            r_fsm   <= StDone;
          end else begin
            r_rnd <= '0;
            r_fsm <= StSqRnd;
          end
        end
        StSqRnd: begin
          r_st  <= w_rnd_st;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == BLast) begin
            r_lane <= r_lane + 1'b1;
            r_fsm  <= StSqueeze;
          end
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign hash_digestxSO = r_dig[0];
  assign hash_readyxSO  = r_ready;
`ifdef ASCON_HASH_STATE_DBG_EN
  assign state_dbgxSO   = r_st;
`else
`endif

endmodule

// File: tb/tb_ascon_serial_hash.sv
// Randomised bench for ascon_serial_hash: an Ascon-Hash instance and an Ascon-Hasha
// instance (y=8, l=100) checked every cycle against a table-driven reference model.
module tb_ascon_serial_hash;

  localparam int P_Y [2] = '{64, 8};
  localparam int P_B [2] = '{12, 8};
  localparam int P_L [2] = '{256, 100};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_bit = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rdy;
  logic [1:0] dig;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef ASCON_HASH_STATE_DBG_EN
  logic [319:0] dbg0;
  logic [319:0] dbg1;
`else
`endif

  ascon_serial_hash u_dut (
    .clk            (clk),
    .rst            (rst),
    .messagexSI     (msg_bit),
    .startxSI       (start),
`ifdef ASCON_HASH_STATE_DBG_EN
    .state_dbgxSO   (dbg0),
`else
`endif
    .hash_digestxSO (dig[0]),
    .hash_readyxSO  (rdy[0])
  );

  ascon_serial_hash #(.Y(8), .B(8), .L(100)) u_dut_hasha (
    .clk            (clk),
    .rst            (rst),
    .messagexSI     (msg_bit),
    .startxSI       (start),
`ifdef ASCON_HASH_STATE_DBG_EN
    .state_dbgxSO   (dbg1),
`else
`endif
    .hash_digestxSO (dig[1]),
    .hash_readyxSO  (rdy[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] ref_iv(int a, int b, int h);
    return {8'h00, 8'd64, 8'(a), 8'(a - b), 32'(h)};
  endfunction

  function automatic logic [319:0] ref_perm(logic [319:0] st, int n);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int k = 0; k < 5; k++) x[k] = st[319-64*k -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = SBOX[col];
        x[0][j] = o[4];
        x[1][j] = o[3];
        x[2][j] = o[2];
        x[3][j] = o[1];
        x[4][j] = o[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [255:0] ref_hash(logic [63:0] m, int y, int a, int b, int l);
    logic [319:0] st;
    logic [63:0]  lane;
    logic [255:0] hv;
    int s, t, j;
    s  = y / 64 + 1;
    t  = (l + 63) / 64;
    hv = '0;
    st = ref_perm({ref_iv(a, b, 256), 256'd0}, a);
    for (int blk = 0; blk < s; blk++) begin
      for (int k = 0; k < 64; k++) begin
        j = 64 * blk + k;
        lane[63-k] = (j < y) ? m[y-1-j] : (j == y);
      end
      st[319:256] = st[319:256] ^ lane;
      st = ref_perm(st, (blk == s - 1) ? a : b);
    end
    for (int q = 0; q < t; q++) begin
      if (q > 0) st = ref_perm(st, b);
      for (int k = 0; k < 64; k++) begin
        j = 64 * q + k;
        if (j < l) hv[l-1-j] = st[319-k];
      end
    end
    return hv;
  endfunction

  function automatic int ref_lat(int y, int a, int b, int l);
    int s, t;
    s = y / 64 + 1;
    t = (l + 63) / 64;
    return 1 + a + (s - 1) * (1 + b) + (1 + a) + t + (t - 1) * b;
  endfunction

  task automatic check(string name, logic [319:0] act, logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state per instance.
  logic [63:0]  m_msg    [2];
  logic         m_busy   [2];
  logic         m_ready  [2];
  logic         m_loaded [2];
  int           m_cnt    [2];
  int           m_n      [2];
  logic [255:0] m_pend   [2];
  logic [255:0] m_dig    [2];
  logic         m_prev;
  logic         p_rst, p_start, p_msg;
  logic [319:0] init_state;

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_msg[i]    = '0;
      m_busy[i]   = 1'b0;
      m_ready[i]  = 1'b0;
      m_loaded[i] = 1'b0;
      m_cnt[i]    = 0;
      m_n[i]      = 0;
      m_dig[i]    = '0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_step(logic st, logic mb);
    logic acc;
    for (int i = 0; i < 2; i++) begin
      acc = st && !m_prev && !m_busy[i];
      if (m_loaded[i]) m_n[i]++;
      if (!m_busy[i]) m_msg[i] = {m_msg[i][62:0], mb};
      if (m_busy[i]) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_busy[i]   = 1'b0;
          m_ready[i]  = 1'b1;
          m_dig[i]    = m_pend[i];
          m_loaded[i] = 1'b1;
          m_n[i]      = 0;
        end
      end
      if (acc) begin
        m_busy[i]  = 1'b1;
        m_ready[i] = 1'b0;
        m_cnt[i]   = ref_lat(P_Y[i], 12, P_B[i], P_L[i]);
        m_pend[i]  = ref_hash(m_msg[i], P_Y[i], 12, P_B[i], P_L[i]);
      end
    end
    m_prev = st;
  endtask

  // Compare process: advance the model by the edge just taken, then check outputs.
  initial begin
    logic exp_d;
    model_clear();
    p_rst   = 1'b1;
    p_start = 1'b0;
    p_msg   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || p_rst) model_clear();
      else              model_step(p_start, p_msg);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready%0d", i), 320'(rdy[i]), 320'(m_ready[i]));
        if (!m_loaded[i])          exp_d = 1'b0;
        else if (m_n[i] <= 2)      exp_d = m_dig[i][0];
        else if (m_n[i] <= P_L[i] + 1) exp_d = m_dig[i][m_n[i]-2];
        else                       exp_d = 1'b0;
        check($sformatf("digest%0d_n%0d", i, m_n[i]), 320'(dig[i]), 320'(exp_d));
      end
`ifdef ASCON_HASH_STATE_DBG_EN
      if (m_busy[0] && (ref_lat(64, 12, 12, 256) - m_cnt[0] == 13))
        check("dbg_init_state", dbg0, init_state);
`else
`endif
      p_rst   = rst;
      p_start = start;
      p_msg   = msg_bit;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Shift 64 bits MSB first; the last bit coincides with the accept edge (start left high).
  task automatic shift_msg(logic [63:0] m);
    start = 1'b0;
    for (int j = 63; j >= 0; j--) begin
      msg_bit = m[j];
      if (j == 0) start = 1'b1;
      tick();
    end
  endtask

  task automatic wait_idle(bit toggle);
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1]) && k < 400) begin
      if (toggle && m_busy[0] && m_busy[1] && m_cnt[0] > 2 && m_cnt[1] > 2)
        start = 1'($urandom_range(0, 1));
      else
        start = 1'b0;
      msg_bit = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    start = 1'b0;
    if (k >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
    end
  endtask

  task automatic idle_cycles(int n);
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      msg_bit = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    int k;
    logic [63:0] m;

    // Pin the model against published constants.
    init_state = ref_perm({ref_iv(12, 12, 256), 256'd0}, 12);
    check("iv_hash", 320'(ref_iv(12, 12, 256)), 320'h00400c0000000100);
    check("iv_hasha", 320'(ref_iv(12, 8, 256)), 320'h00400c0400000100);
    check("init_state", init_state,
          320'hee9398aadb67f03d_8bb21831c60f1002_b48a92db98d5da62_43189921b8f8e3e8_348fa5c9d525e140);
    check("lat_model_hash", 320'(ref_lat(64, 12, 12, 256)), 320'd79);
    check("lat_model_hasha", 320'(ref_lat(8, 12, 8, 100)), 320'd36);

    rst = 1'b1;
    #1;
    check("reset_ready", 320'(rdy), 320'd0);
    check("reset_digest", 320'(dig), 320'd0);
    tick();
    tick();
    rst = 1'b0;
    idle_cycles(3);

    // Known message, start held for three sampled edges, measured latency.
    shift_msg(64'h0001020304050607);
    k = 0;
    while (!rdy[0] && k < 200) begin
      tick();
      k++;
      if (k == 2) start = 1'b0;
    end
    check("latency_hash", 320'(k), 320'd79);
    idle_cycles(P_L[0] + 8);

    // Message ending in 0x00 for the Hasha instance; start toggled while busy.
    m = {32'($urandom), 24'($urandom), 8'h00};
    shift_msg(m);
    wait_idle(1'b1);
    idle_cycles(P_L[0] + 4);

    // Reset in the middle of absorbing.
    shift_msg(64'($urandom) << 32 | 64'($urandom));
    start = 1'b0;
    idle_cycles(20);
    rst = 1'b1;
    #1;
    check("midrst_ready", 320'(rdy), 320'd0);
    check("midrst_digest", 320'(dig), 320'd0);
    tick();
    tick();
    rst = 1'b0;
    shift_msg(64'hfedcba9876543210);
    wait_idle(1'b0);

    // New message while the previous digest is still being shifted out.
    idle_cycles(10);
    shift_msg(64'($urandom) << 32 | 64'($urandom));
    wait_idle(1'b1);
    idle_cycles(P_L[0] + 4);

    // Randomised runs.
    for (int run = 0; run < 6; run++) begin
      shift_msg(64'($urandom) << 32 | 64'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
      wait_idle(1'b1);
      idle_cycles(int'($urandom_range(0, 300)));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
